// File: rtl/dmem_pkg.sv
// Shared size encodings and lane helpers for the data-memory arbiter.
package dmem_pkg;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;
  localparam logic [1:0] SIZE_X = 2'd3;

  // Misaligned half/word or the reserved size code.
  function automatic logic lane_err(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SIZE_B:  lane_err = 1'b0;
      SIZE_H:  lane_err = off[0];
      SIZE_W:  lane_err = |off;
      default: lane_err = 1'b1;
    endcase
  endfunction

  // Byte write enables for a store; all-zero when the access is rejected.
  function automatic logic [3:0] lane_wea(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SIZE_B:  lane_wea = 4'b0001 << off;
      SIZE_H:  lane_wea = 4'b0011 << off;
      SIZE_W:  lane_wea = 4'b1111;
      default: lane_wea = '0;
    endcase
    if (lane_err(size, off)) lane_wea = '0;
  endfunction

  // Pick the addressed byte/half out of a RAM word and extend it to 32 bits.
  function automatic logic [31:0] lane_extract(input logic [31:0] word, input logic [1:0] size,
                                               input logic [1:0] off, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{off, 3'b000} +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (size)
      SIZE_B:  lane_extract = uns ? {24'b0, b} : {{24{b[7]}}, b};
      SIZE_H:  lane_extract = uns ? {16'b0, h} : {{16{h[15]}}, h};
      default: lane_extract = word;
    endcase
  endfunction

endpackage

// File: rtl/dmem_lane.sv
// Combinational lane logic: store enables/replicated data and load extraction.
module dmem_lane
  import dmem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  off,
  input  logic        uns,
  input  logic [31:0] wdata_in,
  input  logic [31:0] rdata_in,
  output logic        err,
  output logic [3:0]  wea,
  output logic [31:0] wdata_out,
  output logic [31:0] rdata_out
);

  // Lane generation for stores and extraction/extension for loads.
  always_comb begin
    err       = lane_err(size, off);
    wea       = lane_wea(size, off);
    rdata_out = lane_extract(rdata_in, size, off, uns);
    case (size)
      SIZE_B:  wdata_out = {4{wdata_in[7:0]}};
      SIZE_H:  wdata_out = {2{wdata_in[15:0]}};
      default: wdata_out = wdata_in;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port round-robin data-memory controller in front of a negedge RAM.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 17
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  p0_req_valid,
  output logic                  p0_req_ready,
  input  logic                  p0_req_we,
  input  logic [ADDR_WIDTH+1:0] p0_req_addr,
  input  logic [1:0]            p0_req_size,
  input  logic                  p0_req_unsigned,
  input  logic [31:0]           p0_req_wdata,
  output logic                  p0_rsp_valid,
  output logic [31:0]           p0_rsp_rdata,
  output logic                  p0_rsp_err,
  input  logic                  p1_req_valid,
  output logic                  p1_req_ready,
  input  logic                  p1_req_we,
  input  logic [ADDR_WIDTH+1:0] p1_req_addr,
  input  logic [1:0]            p1_req_size,
  input  logic                  p1_req_unsigned,
  input  logic [31:0]           p1_req_wdata,
  output logic                  p1_rsp_valid,
  output logic [31:0]           p1_rsp_rdata,
  output logic                  p1_rsp_err,
  output logic [ADDR_WIDTH-1:0] ram_raddr,
  output logic [ADDR_WIDTH-1:0] ram_waddr,
  output logic [31:0]           ram_wdata,
  output logic [3:0]            ram_wea,
  input  logic [31:0]           ram_rdata
);

  logic                  ptr;
  logic                  accept;
  logic                  grant1;
  logic                  sel_we;
  logic                  sel_uns;
  logic [ADDR_WIDTH+1:0] sel_addr;
  logic [1:0]            sel_size;
  logic [31:0]           sel_wdata;

  logic                  req_err;
  logic [3:0]            req_wea;
  logic [31:0]           req_wdata;
  logic [31:0]           req_rdata_x;

  logic                  rsp_v;
  logic                  rsp_port;
  logic                  rsp_we;
  logic                  rsp_err;
  logic                  rsp_uns;
  logic [1:0]            rsp_size;
  logic [1:0]            rsp_off;
  logic [31:0]           rsp_word;
  logic [31:0]           rsp_ext;
  logic [31:0]           rsp_data;
  logic                  rsp_err_x;
  logic [3:0]            rsp_wea_x;
  logic [31:0]           rsp_wdata_x;
  logic                  unused_lane;

  // Round-robin grant: on contention the port other than the last grant wins.
  always_comb begin
    p0_req_ready = 1'b0;
    p1_req_ready = 1'b0;
    if (!rst) begin
      p0_req_ready = p0_req_valid && (!p1_req_valid || ptr);
      p1_req_ready = p1_req_valid && (!p0_req_valid || !ptr);
    end
    accept = p0_req_ready || p1_req_ready;
    grant1 = p1_req_ready;
  end

  // Request field mux; port 0 fields drive the RAM when nothing is accepted.
  always_comb begin
    sel_we    = p0_req_we;
    sel_uns   = p0_req_unsigned;
    sel_addr  = p0_req_addr;
    sel_size  = p0_req_size;
    sel_wdata = p0_req_wdata;
    if (grant1) begin
      sel_we    = p1_req_we;
      sel_uns   = p1_req_unsigned;
      sel_addr  = p1_req_addr;
      sel_size  = p1_req_size;
      sel_wdata = p1_req_wdata;
    end
  end

  dmem_lane u_req_lane (
    .size      (sel_size),
    .off       (sel_addr[1:0]),
    .uns       (sel_uns),
    .wdata_in  (sel_wdata),
    .rdata_in  ('0),
    .err       (req_err),
    .wea       (req_wea),
    .wdata_out (req_wdata),
    .rdata_out (req_rdata_x)
  );

  // RAM drive: write enables only for an accepted, legal store.
  always_comb begin
    ram_raddr = sel_addr[ADDR_WIDTH+1:2];
    ram_waddr = sel_addr[ADDR_WIDTH+1:2];
    ram_wdata = req_wdata;
    ram_wea   = (accept && sel_we) ? req_wea : '0;
  end

  // Pointer and response stage; the RAM word read at the negedge is captured here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr      <= 1'b1;
      rsp_v    <= 1'b0;
      rsp_port <= 1'b0;
      rsp_we   <= 1'b0;
      rsp_err  <= 1'b0;
      rsp_uns  <= 1'b0;
      rsp_size <= SIZE_B;
      rsp_off  <= '0;
      rsp_word <= '0;
    end else begin
      rsp_v <= accept;
      if (accept) begin
        ptr      <= grant1;
        rsp_port <= grant1;
        rsp_we   <= sel_we;
        rsp_err  <= req_err;
        rsp_uns  <= sel_uns;
        rsp_size <= sel_size;
        rsp_off  <= sel_addr[1:0];
        rsp_word <= ram_rdata;
      end
    end
  end

  dmem_lane u_rsp_lane (
    .size      (rsp_size),
    .off       (rsp_off),
    .uns       (rsp_uns),
    .wdata_in  ('0),
    .rdata_in  (rsp_word),
    .err       (rsp_err_x),
    .wea       (rsp_wea_x),
    .wdata_out (rsp_wdata_x),
    .rdata_out (rsp_ext)
  );

  assign unused_lane = ^{req_rdata_x, rsp_err_x, rsp_wea_x, rsp_wdata_x};

  // Route the response to the owning port; stores and errors return zero data.
  always_comb begin
    rsp_data     = (rsp_v && !rsp_we && !rsp_err) ? rsp_ext : '0;
    p0_rsp_valid = rsp_v && !rsp_port;
    p1_rsp_valid = rsp_v && rsp_port;
    p0_rsp_rdata = rsp_port ? '0 : rsp_data;
    p1_rsp_rdata = rsp_port ? rsp_data : '0;
    p0_rsp_err   = p0_rsp_valid && rsp_err;
    p1_rsp_err   = p1_rsp_valid && rsp_err;
  end

endmodule
